// File: rtl/burst_arbiter_ctrl_if.sv
// Bus bundle between the two burst requesters, the arbiter controller and the
// shared burst memory datapath.
interface burst_arbiter_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 8,
  parameter int LEN_WIDTH  = $clog2(BURST_LEN + 1)
);
  logic [1:0]              req;
  logic [1:0]              req_wr;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*LEN_WIDTH-1:0]  req_len;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [1:0]              gnt;
  logic [1:0]              beat_ack;
  logic [1:0]              rd_valid;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [1:0]              len_err;
  logic                    busy;
  logic                    mem_burst_en;
  logic [ADDR_WIDTH-1:0]   mem_addr_top;
  logic                    mem_wren;
  logic                    mem_rden;
  logic [DATA_WIDTH-1:0]   mem_wr_data;
  logic [DATA_WIDTH-1:0]   mem_rd_data;

  modport master (
    output req, req_wr, req_addr, req_len, req_wdata, mem_rd_data,
    input  gnt, beat_ack, rd_valid, rd_data, len_err, busy,
           mem_burst_en, mem_addr_top, mem_wren, mem_rden, mem_wr_data
  );

  modport slave (
    input  req, req_wr, req_addr, req_len, req_wdata, mem_rd_data,
    output gnt, beat_ack, rd_valid, rd_data, len_err, busy,
           mem_burst_en, mem_addr_top, mem_wren, mem_rden, mem_wr_data
  );
endinterface

// File: rtl/burst_arbiter_ctrl.sv
// Round-robin arbiter for two burst requesters sharing one burst memory;
// sequences one beat per cycle and keeps burst_en runs below BURST_LEN.
module burst_arbiter_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 8,
  parameter int LEN_WIDTH  = $clog2(BURST_LEN + 1)
) (
  input logic                 clk,
  input logic                 rstn,
  burst_arbiter_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_e;

  state_e                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  win_q, win_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rd_valid_q, rd_valid_d;

  logic [LEN_WIDTH-1:0]  len0, len1;
  logic [1:0]            len_err, elig;
  logic                  pick;

  assign len0 = bus.req_len[0 +: LEN_WIDTH];
  assign len1 = bus.req_len[LEN_WIDTH +: LEN_WIDTH];

  always_comb begin
    len_err[0] = bus.req[0] && ((len0 == '0) || (len0 > LEN_WIDTH'(BURST_LEN)));
    len_err[1] = bus.req[1] && ((len1 == '0) || (len1 > LEN_WIDTH'(BURST_LEN)));
    elig       = bus.req & ~len_err;
    // On a tie the master that did not win last time goes next.
    pick       = (elig == 2'b11) ? ~rr_q : elig[1];
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    win_d   = win_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          win_d   = pick;
          rr_d    = pick;
          gnt_d   = pick ? 2'b10 : 2'b01;
          addr_d  = pick ? bus.req_addr[ADDR_WIDTH +: ADDR_WIDTH] : bus.req_addr[0 +: ADDR_WIDTH];
          len_d   = pick ? len1 : len0;
          wr_d    = bus.req_wr[pick];
          beat_d  = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        beat_d = beat_q + 1'b1;
        if (beat_q == len_q - 1'b1) state_d = DRAIN;
      end
      DRAIN: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_burst_en = 1'b0;
    bus.mem_addr_top = '0;
    bus.mem_wren     = 1'b0;
    bus.mem_rden     = 1'b0;
    bus.mem_wr_data  = '0;
    bus.beat_ack     = '0;
    rd_valid_d       = '0;
    if (state_q == XFER) begin
      bus.mem_burst_en = (beat_q != '0);
      bus.mem_addr_top = addr_q + ADDR_WIDTH'(beat_q);
      bus.mem_wren     = wr_q;
      bus.mem_rden     = ~wr_q;
      if (wr_q) begin
        bus.mem_wr_data = win_q ? bus.req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                : bus.req_wdata[0 +: DATA_WIDTH];
      end
      bus.beat_ack = win_q ? 2'b10 : 2'b01;
      if (!wr_q) rd_valid_d = win_q ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rr_q       <= 1'b1;
      win_q      <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      gnt_q      <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      win_q      <= win_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Memory registers its own read output, so the data is already aligned
  // with the registered rd_valid one cycle after the read beat.
  assign bus.rd_data  = (|rd_valid_q) ? bus.mem_rd_data : '0;
  assign bus.rd_valid = rd_valid_q;
  assign bus.gnt      = gnt_q;
  assign bus.len_err  = len_err;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_burst_arbiter_ctrl.sv
// Scoreboard bench for burst_arbiter_ctrl: expected beats and read data are
// queued as requests are issued and checked as the DUT produces them.
module tb_burst_arbiter_ctrl;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int BL = 8;
  localparam int LW = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic          ben;
    logic [DW-1:0] wd;
    logic          m;
  } beat_t;

  typedef struct packed {
    logic          m;
    logic [DW-1:0] d;
  } rd_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  burst_arbiter_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .LEN_WIDTH(LW)) bus ();

  burst_arbiter_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL), .LEN_WIDTH(LW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  beat_t         exp_q[$];
  rd_t           rd_q[$];
  logic [DW-1:0] wq0[$];
  logic [DW-1:0] wq1[$];
  logic [DW-1:0] ref_mem[32];
  logic [DW-1:0] sim_mem[32];
  logic [DW-1:0] wbuf[8];
  logic          last_win;

  // Memory model: synchronous write, registered read output.
  always @(posedge clk) begin
    if (bus.mem_wren) sim_mem[bus.mem_addr_top] <= bus.mem_wr_data;
    if (bus.mem_rden) bus.mem_rd_data <= sim_mem[bus.mem_addr_top];
  end

  // Monitor and per-master write-data presenters.
  int   run_len = 0;
  logic ack0, ack1;
  always @(negedge clk) begin
    beat_t e;
    rd_t   r;
    if (rstn) begin
      if (bus.mem_wren || bus.mem_rden) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected: got addr=%0h wren=%0b rden=%0b ack=%b, required no beat",
                   bus.mem_addr_top, bus.mem_wren, bus.mem_rden, bus.beat_ack);
        end else begin
          e = exp_q.pop_front();
          if ({bus.mem_addr_top, bus.mem_wren, bus.mem_rden, bus.mem_burst_en, bus.mem_wr_data, bus.beat_ack}
              !== {e.addr, e.wr, ~e.wr, e.ben, e.wd, (e.m ? 2'b10 : 2'b01)}) begin
            bad++;
            $display("FAIL beat: got addr=%0h wren=%0b rden=%0b ben=%0b wdata=%0h ack=%b, required addr=%0h wren=%0b rden=%0b ben=%0b wdata=%0h ack=%b",
                     bus.mem_addr_top, bus.mem_wren, bus.mem_rden, bus.mem_burst_en, bus.mem_wr_data, bus.beat_ack,
                     e.addr, e.wr, ~e.wr, e.ben, e.wd, (e.m ? 2'b10 : 2'b01));
          end
        end
      end else if (bus.beat_ack !== 2'b00 || bus.mem_burst_en !== 1'b0) begin
        total++;
        bad++;
        $display("FAIL idle_strobe: got ack=%b ben=%0b, required ack=00 ben=0", bus.beat_ack, bus.mem_burst_en);
      end
      if (bus.rd_valid !== 2'b00) begin
        total++;
        if (rd_q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected: got rd_valid=%b rd_data=%0h, required no read data", bus.rd_valid, bus.rd_data);
        end else begin
          r = rd_q.pop_front();
          if ({bus.rd_valid, bus.rd_data} !== {(r.m ? 2'b10 : 2'b01), r.d}) begin
            bad++;
            $display("FAIL rd_data: got rd_valid=%b rd_data=%0h, required rd_valid=%b rd_data=%0h",
                     bus.rd_valid, bus.rd_data, (r.m ? 2'b10 : 2'b01), r.d);
          end
        end
      end
      if (bus.mem_burst_en) begin
        run_len++;
        total++;
        if (run_len > BL - 1) begin
          bad++;
          $display("FAIL burst_en_run: got %0d consecutive cycles, required at most %0d", run_len, BL - 1);
        end
      end else begin
        run_len = 0;
      end
    end else begin
      run_len = 0;
    end
    ack0 = bus.beat_ack[0];
    ack1 = bus.beat_ack[1];
    @(posedge clk);
    #1;
    if (ack0 && wq0.size() > 0) void'(wq0.pop_front());
    if (ack1 && wq1.size() > 0) void'(wq1.pop_front());
    bus.req_wdata = {((wq1.size() > 0) ? wq1[0] : 8'h00), ((wq0.size() > 0) ? wq0[0] : 8'h00)};
  end

  task automatic push_burst(input logic m, input logic wr, input logic [AW-1:0] addr, input int len);
    beat_t e;
    rd_t   r;
    for (int b = 0; b < len; b++) begin
      e.addr = addr + AW'(b);
      e.wr   = wr;
      e.ben  = (b != 0);
      e.wd   = wr ? wbuf[b] : 8'h00;
      e.m    = m;
      exp_q.push_back(e);
      if (wr) begin
        ref_mem[e.addr] = wbuf[b];
        if (m) wq1.push_back(wbuf[b]);
        else   wq0.push_back(wbuf[b]);
      end else begin
        r.m = m;
        r.d = ref_mem[e.addr];
        rd_q.push_back(r);
      end
    end
  endtask

  task automatic set_req(input logic m, input logic wr, input logic [AW-1:0] addr, input int len);
    bus.req[m]                = 1'b1;
    bus.req_wr[m]             = wr;
    bus.req_addr[m*AW +: AW]  = addr;
    bus.req_len[m*LW +: LW]   = LW'(len);
  endtask

  // Drives one burst; returns edges to grant, grant cycles and read data still
  // outstanding at the DRAIN cycle.
  task automatic do_burst(input logic m, input logic wr, input logic [AW-1:0] addr, input int len,
                          output int lat, output int gcyc, output int rd_left);
    lat     = 0;
    gcyc    = 0;
    rd_left = -1;
    push_burst(m, wr, addr, len);
    last_win = m;
    set_req(m, wr, addr, len);
    do begin
      @(negedge clk); #1;
      lat++;
    end while (!bus.gnt[m] && lat < 50);
    bus.req[m] = 1'b0;
    while (bus.gnt[m] && gcyc < 50) begin
      gcyc++;
      rd_left = rd_q.size();
      @(negedge clk); #1;
    end
    for (int i = 0; i < 20 && (exp_q.size() > 0 || rd_q.size() > 0); i++) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rstn          = 1'b0;
    bus.req       = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    last_win      = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({bus.gnt, bus.beat_ack, bus.rd_valid, bus.busy} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctl: got gnt=%b ack=%b rd_valid=%b busy=%0b, required all 0",
               bus.gnt, bus.beat_ack, bus.rd_valid, bus.busy);
    end
    total++;
    if ({bus.mem_burst_en, bus.mem_wren, bus.mem_rden} !== 3'b0) begin
      bad++;
      $display("FAIL reset_strobes: got ben=%0b wren=%0b rden=%0b, required 0 0 0",
               bus.mem_burst_en, bus.mem_wren, bus.mem_rden);
    end
    total++;
    if ({bus.rd_data, bus.mem_addr_top, bus.mem_wr_data} !== '0) begin
      bad++;
      $display("FAIL reset_data: got rd_data=%0h addr=%0h wr_data=%0h, required 0 0 0",
               bus.rd_data, bus.mem_addr_top, bus.mem_wr_data);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_write;
    int lat, g, rl;
    wbuf[0] = 8'h17; wbuf[1] = 8'h18; wbuf[2] = 8'h19; wbuf[3] = 8'h1A;
    do_burst(1'b0, 1'b1, 5'd7, 4, lat, g, rl);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL write_latency: got %0d edges, required 1", lat); end
    total++;
    if (g !== 5) begin bad++; $display("FAIL write_gnt_cycles: got %0d, required 5", g); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL write_beats_left: got %0d, required 0", exp_q.size()); end
    total++;
    if ({sim_mem[7], sim_mem[8], sim_mem[9], sim_mem[10]} !== 32'h1718191A) begin
      bad++;
      $display("FAIL write_mem: got %0h %0h %0h %0h, required 17 18 19 1a", sim_mem[7], sim_mem[8], sim_mem[9], sim_mem[10]);
    end
  endtask

  task automatic test_read;
    int lat, g, rl;
    do_burst(1'b0, 1'b0, 5'd7, 4, lat, g, rl);
    total++;
    if (g !== 5) begin bad++; $display("FAIL read_gnt_cycles: got %0d, required 5", g); end
    total++;
    if (rl !== 0) begin bad++; $display("FAIL read_drain: got %0d reads pending after DRAIN, required 0", rl); end
    total++;
    if (rd_q.size() !== 0) begin bad++; $display("FAIL read_left: got %0d, required 0", rd_q.size()); end
  endtask

  task automatic test_wrap;
    int lat, g, rl;
    wbuf[0] = 8'h5A; wbuf[1] = 8'h5B; wbuf[2] = 8'h5C; wbuf[3] = 8'h5D;
    do_burst(1'b1, 1'b1, 5'h1E, 4, lat, g, rl);
    total++;
    if (g !== 5) begin bad++; $display("FAIL wrap_gnt_cycles: got %0d, required 5", g); end
    total++;
    if ({sim_mem[30], sim_mem[31], sim_mem[0], sim_mem[1]} !== 32'h5A5B5C5D) begin
      bad++;
      $display("FAIL wrap_mem: got %0h %0h %0h %0h, required 5a 5b 5c 5d", sim_mem[30], sim_mem[31], sim_mem[0], sim_mem[1]);
    end
    total++;
    if (bus.len_err !== 2'b00) begin bad++; $display("FAIL wrap_len_err: got %b, required 00", bus.len_err); end
  endtask

  task automatic test_round_robin;
    logic       first, m;
    logic [1:0] want;
    int         hi, lo, w;
    first = ~last_win;
    for (int k = 0; k < 4; k++) begin
      m = first ^ k[0];
      wbuf[0] = 8'hA0 + 8'(k * 2);
      wbuf[1] = 8'hA1 + 8'(k * 2);
      push_burst(m, 1'b1, (m ? 5'h14 : 5'h10), 2);
    end
    last_win = ~first;
    set_req(1'b0, 1'b1, 5'h10, 2);
    set_req(1'b1, 1'b1, 5'h14, 2);
    for (int k = 0; k < 4; k++) begin
      m    = first ^ k[0];
      want = m ? 2'b10 : 2'b01;
      w    = 0;
      while (bus.gnt == 2'b00 && w < 20) begin w++; @(negedge clk); #1; end
      total++;
      if (bus.gnt !== want) begin bad++; $display("FAIL rr_grant%0d: got gnt=%b, required %b", k, bus.gnt, want); end
      if (k == 3) bus.req = 2'b00;
      hi = 0;
      while (bus.gnt != 2'b00 && hi < 20) begin hi++; @(negedge clk); #1; end
      total++;
      if (hi !== 3) begin bad++; $display("FAIL rr_gnt_cycles%0d: got %0d, required 3", k, hi); end
      if (k < 3) begin
        lo = 0;
        while (bus.gnt == 2'b00 && lo < 20) begin lo++; @(negedge clk); #1; end
        total++;
        if (lo !== 1) begin bad++; $display("FAIL rr_idle_gap%0d: got %0d cycles, required 1", k, lo); end
      end
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin @(negedge clk); #1; end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL rr_beats_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_len_err;
    logic g0_seen;
    int   w;
    push_burst(1'b1, 1'b0, 5'd7, 1);
    last_win = 1'b1;
    @(negedge clk); #1;
    set_req(1'b0, 1'b1, 5'd3, 0);
    set_req(1'b1, 1'b0, 5'd7, 1);
    #1;
    total++;
    if (bus.len_err !== 2'b01) begin bad++; $display("FAIL len0_err: got %b, required 01", bus.len_err); end
    g0_seen = 1'b0;
    w = 0;
    while (bus.gnt == 2'b00 && w < 20) begin w++; @(negedge clk); #1; end
    total++;
    if (bus.gnt !== 2'b10) begin bad++; $display("FAIL len_err_valid_gnt: got gnt=%b, required 10", bus.gnt); end
    bus.req[1] = 1'b0;
    w = 0;
    while (bus.gnt != 2'b00 && w < 20) begin g0_seen |= bus.gnt[0]; w++; @(negedge clk); #1; end
    for (int i = 0; i < 3; i++) begin
      g0_seen |= bus.gnt[0];
      total++;
      if ({bus.gnt, bus.busy, bus.mem_wren, bus.mem_rden, bus.mem_burst_en, bus.len_err} !== 8'b0000_0001) begin
        bad++;
        $display("FAIL len0_idle%0d: got gnt=%b busy=%0b wren=%0b rden=%0b ben=%0b len_err=%b, required gnt=00 busy=0 strobes=0 len_err=01",
                 i, bus.gnt, bus.busy, bus.mem_wren, bus.mem_rden, bus.mem_burst_en, bus.len_err);
      end
      @(negedge clk); #1;
    end
    bus.req_len[0 +: LW] = LW'(9);
    #1;
    total++;
    if (bus.len_err !== 2'b01) begin bad++; $display("FAIL len9_err: got %b, required 01", bus.len_err); end
    for (int i = 0; i < 3; i++) begin
      g0_seen |= bus.gnt[0];
      total++;
      if ({bus.gnt, bus.busy} !== 3'b000) begin
        bad++;
        $display("FAIL len9_idle%0d: got gnt=%b busy=%0b, required 00 0", i, bus.gnt, bus.busy);
      end
      @(negedge clk); #1;
    end
    total++;
    if (g0_seen !== 1'b0) begin bad++; $display("FAIL len_err_granted: got gnt[0] seen=%0b, required 0", g0_seen); end
    bus.req[0] = 1'b0;
    #1;
    total++;
    if (bus.len_err !== 2'b00) begin bad++; $display("FAIL len_err_clear: got %b, required 00", bus.len_err); end
    total++;
    if (rd_q.size() !== 0) begin bad++; $display("FAIL len_err_read_left: got %0d, required 0", rd_q.size()); end
  endtask

  task automatic test_reset_mid_burst;
    beat_t e;
    int    w, lat, g, rl;
    for (int b = 0; b < 8; b++) begin
      e.addr = 5'h08 + AW'(b);
      e.wr   = 1'b1;
      e.ben  = (b != 0);
      e.wd   = 8'h60 + 8'(b);
      e.m    = 1'b0;
      exp_q.push_back(e);
      wq0.push_back(e.wd);
      if (b < 2) ref_mem[e.addr] = e.wd;
    end
    @(negedge clk); #1;
    set_req(1'b0, 1'b1, 5'h08, 8);
    w = 0;
    do begin @(negedge clk); #1; w++; end while (!bus.gnt[0] && w < 20);
    bus.req[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({bus.mem_wren, bus.mem_addr_top} !== {1'b1, 5'h0A}) begin
      bad++;
      $display("FAIL mid_beat2: got wren=%0b addr=%0h, required 1 0a", bus.mem_wren, bus.mem_addr_top);
    end
    rstn = 1'b0;
    #1;
    exp_q.delete();
    wq0.delete();
    rd_q.delete();
    last_win = 1'b1;
    total++;
    if ({bus.gnt, bus.beat_ack, bus.busy, bus.mem_wren, bus.mem_rden, bus.mem_burst_en} !== 8'b0) begin
      bad++;
      $display("FAIL mid_reset_strobes: got gnt=%b ack=%b busy=%0b wren=%0b rden=%0b ben=%0b, required all 0",
               bus.gnt, bus.beat_ack, bus.busy, bus.mem_wren, bus.mem_rden, bus.mem_burst_en);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    do_burst(1'b1, 1'b0, 5'h08, 2, lat, g, rl);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL post_reset_m1_latency: got %0d edges, required 1", lat); end
    total++;
    if (g !== 3) begin bad++; $display("FAIL post_reset_gnt_cycles: got %0d, required 3", g); end
    total++;
    if (rd_q.size() !== 0) begin bad++; $display("FAIL post_reset_read_left: got %0d, required 0", rd_q.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_round_robin();
    test_len_err();
    test_reset_mid_burst();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $fatal(1);
  end
endmodule
